// File: rtl/rd_fwft_stage.sv
// rd_fwft_stage: issues RAM reads, absorbs read latency, presents words as a FWFT valid/ready stream
module rd_fwft_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [2:0]            obuf_level
);
  localparam int OBUF_DEPTH = RAM_LATENCY + 2;
  logic [RAM_LATENCY-1:0] trk;
  logic [2:0] inflight;
  logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic cap, pop;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + 3'(trk[i]);
  end
  assign cap = trk[RAM_LATENCY-1];
  assign pop = m_valid & m_ready;
  assign rinc = ~rrst & ~rempty & (({1'b0, obuf_level} + {1'b0, inflight}) < 4'(OBUF_DEPTH));
  assign m_valid = obuf_level != '0;
  assign m_data = obuf[rd_ptr];
  always_ff @(posedge rclk) begin
    if (rrst) begin
      trk <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      obuf_level <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else begin
      trk <= (trk << 1) | RAM_LATENCY'(rinc);
      if (cap) obuf[wr_ptr] <= rdata;
      if (cap) wr_ptr <= (wr_ptr == 2'(OBUF_DEPTH - 1)) ? '0 : wr_ptr + 2'd1;
      if (pop) rd_ptr <= (rd_ptr == 2'(OBUF_DEPTH - 1)) ? '0 : rd_ptr + 2'd1;
      obuf_level <= obuf_level + 3'(cap) - 3'(pop);
    end
  end
  always_ff @(posedge rclk)
    if (!rrst) assert (!(cap && obuf_level == 3'(OBUF_DEPTH)));
endmodule

// File: tb/tb_rd_fwft_stage.sv
// tb_rd_fwft_stage: scoreboard bench driving latency-1 and latency-2 instances through a FIFO/RAM model
module tb_rd_fwft_stage;
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  logic rempty [2] = '{1'b1, 1'b1};
  logic rinc [2];
  logic [7:0] rdata [2];
  logic m_valid [2];
  logic m_ready [2] = '{1'b0, 1'b0};
  logic [7:0] m_data [2];
  logic [2:0] obuf_level [2];
  logic hold [2] = '{1'b0, 1'b0};
  int bad_cnt [2] = '{0, 0};
  logic [7:0] src_q [2][$];
  logic [7:0] exp_q [2][$];
  int errors = 0;
  int checks = 0;

  always #5 rclk = ~rclk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [7:0] p0 = 8'hEE;
    logic [7:0] p1 = 8'hEE;
    rd_fwft_stage #(.DATA_WIDTH(8), .RAM_LATENCY(g + 1)) dut (
      .rclk(rclk), .rrst(rrst), .rempty(rempty[g]), .rinc(rinc[g]), .rdata(rdata[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]), .obuf_level(obuf_level[g])
    );
    assign rdata[g] = (g == 0) ? p0 : p1;
    always @(posedge rclk) begin
      if (rinc[g] && rempty[g]) bad_cnt[g] <= bad_cnt[g] + 1;
      if (rinc[g] && src_q[g].size() != 0) p0 <= src_q[g].pop_front();
      else p0 <= 8'hEE;
      p1 <= p0;
      rempty[g] <= hold[g] || src_q[g].size() == 0;
    end
  end

  task automatic push(input int k, input logic [7:0] w);
    src_q[k].push_back(w);
    exp_q[k].push_back(w);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rrst = 1'b1;
    m_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 8'h30 + 8'(i));
    repeat (3) begin
      @(negedge rclk);
      checks++;
      if (rinc[0] !== 1'b0 || m_valid[0] !== 1'b0 || obuf_level[0] !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold: rinc=%b m_valid=%b level=%0d, expected 0 0 0", rinc[0], m_valid[0], obuf_level[0]);
      end
    end
    rrst = 1'b0;
    m_ready[0] = 1'b1;
    #1;
    checks++;
    if (rinc[0] !== 1'b1) begin errors++; $display("FAIL reset_first_rinc: got %b expected 1", rinc[0]); end
    @(negedge rclk);
    checks++;
    if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_latency_early: m_valid=%b expected 0", m_valid[0]); end
    @(negedge rclk);
    checks++;
    if (m_valid[0] !== 1'b1) begin errors++; $display("FAIL reset_latency: m_valid=%b expected 1", m_valid[0]); end
    for (int c = 0; c < 20 && exp_q[0].size() != 0; c++) begin
      if (c != 0) @(negedge rclk);
      if (m_valid[0] && m_ready[0]) begin
        e = exp_q[0].size() != 0 ? exp_q[0].pop_front() : 8'hxx;
        checks++;
        if (m_data[0] !== e) begin errors++; $display("FAIL reset_data: got %h expected %h", m_data[0], e); end
      end
    end
    checks++;
    if (exp_q[0].size() != 0) begin errors++; $display("FAIL reset_drain: %0d words left, expected 0", exp_q[0].size()); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    int n_rinc = 0;
    int n_val = 0;
    repeat (3) @(negedge rclk);
    m_ready[0] = 1'b1;
    push(0, 8'hA5);
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      n_rinc += int'(rinc[0]);
      if (m_valid[0]) n_val++;
      if (m_valid[0] && m_ready[0]) begin
        e = exp_q[0].size() != 0 ? exp_q[0].pop_front() : 8'hxx;
        checks++;
        if (m_data[0] !== e) begin errors++; $display("FAIL single_data: got %h expected %h", m_data[0], e); end
      end
    end
    checks++;
    if (n_rinc != 1) begin errors++; $display("FAIL single_rinc: got %0d pulses expected 1", n_rinc); end
    checks++;
    if (n_val != 1) begin errors++; $display("FAIL single_valid: got %0d cycles expected 1", n_val); end
    checks++;
    if (rinc[0] !== 1'b0) begin errors++; $display("FAIL single_idle: rinc=%b expected 0", rinc[0]); end
  endtask

  task automatic test_burst();
    logic [7:0] e;
    int run_r = 0, run_v = 0, max_r = 0, max_v = 0, max_l = 0;
    repeat (3) @(negedge rclk);
    m_ready[1] = 1'b1;
    for (int i = 0; i < 16; i++) push(1, 8'(i));
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      run_r = rinc[1] ? run_r + 1 : 0;
      run_v = m_valid[1] ? run_v + 1 : 0;
      max_r = run_r > max_r ? run_r : max_r;
      max_v = run_v > max_v ? run_v : max_v;
      max_l = int'(obuf_level[1]) > max_l ? int'(obuf_level[1]) : max_l;
      if (m_valid[1] && m_ready[1]) begin
        e = exp_q[1].size() != 0 ? exp_q[1].pop_front() : 8'hxx;
        checks++;
        if (m_data[1] !== e) begin errors++; $display("FAIL burst_data: got %h expected %h", m_data[1], e); end
      end
    end
    checks++;
    if (max_r != 16) begin errors++; $display("FAIL burst_rinc_run: got %0d expected 16", max_r); end
    checks++;
    if (max_v != 16) begin errors++; $display("FAIL burst_valid_run: got %0d expected 16", max_v); end
    checks++;
    if (max_l > 4) begin errors++; $display("FAIL burst_level: peak %0d expected at most 4", max_l); end
    checks++;
    if (exp_q[1].size() != 0) begin errors++; $display("FAIL burst_drain: %0d words left, expected 0", exp_q[1].size()); end
  endtask

  task automatic test_backpressure(input int k);
    logic [7:0] e;
    int n_rinc = 0;
    repeat (3) @(negedge rclk);
    m_ready[k] = 1'b0;
    for (int i = 0; i < 10; i++) push(k, 8'h50 + 8'(i));
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      n_rinc += int'(rinc[k]);
    end
    checks++;
    if (n_rinc != k + 3) begin errors++; $display("FAIL bp_issue_L%0d: got %0d issues expected %0d", k + 1, n_rinc, k + 3); end
    checks++;
    if (obuf_level[k] !== 3'(k + 3)) begin errors++; $display("FAIL bp_level_L%0d: got %0d expected %0d", k + 1, obuf_level[k], k + 3); end
    for (int c = 0; c < 40 && exp_q[k].size() != 0; c++) begin
      @(negedge rclk);
      m_ready[k] = 1'b1;
      if (m_valid[k] && m_ready[k]) begin
        e = exp_q[k].size() != 0 ? exp_q[k].pop_front() : 8'hxx;
        checks++;
        if (m_data[k] !== e) begin errors++; $display("FAIL bp_data_L%0d: got %h expected %h", k + 1, m_data[k], e); end
      end
    end
    checks++;
    if (exp_q[k].size() != 0) begin errors++; $display("FAIL bp_drain_L%0d: %0d words left, expected 0", k + 1, exp_q[k].size()); end
  endtask

  task automatic test_random(input int k);
    logic [7:0] e;
    logic [7:0] held = '0;
    logic stall = 1'b0;
    int lvl_bad = 0;
    repeat (3) @(negedge rclk);
    for (int i = 0; i < 1000; i++) push(k, 8'($urandom));
    for (int c = 0; c < 20000 && exp_q[k].size() != 0; c++) begin
      @(negedge rclk);
      if (stall) begin
        checks++;
        if (m_valid[k] !== 1'b1 || m_data[k] !== held) begin
          errors++;
          $display("FAIL rand_stable_L%0d: m_valid=%b m_data=%h expected 1 %h", k + 1, m_valid[k], m_data[k], held);
        end
      end
      if (int'(obuf_level[k]) > k + 3) lvl_bad++;
      m_ready[k] = 1'($urandom_range(1, 0));
      if ($urandom_range(9, 0) == 0) hold[k] = ~hold[k];
      if (m_valid[k] && m_ready[k]) begin
        e = exp_q[k].size() != 0 ? exp_q[k].pop_front() : 8'hxx;
        checks++;
        if (m_data[k] !== e) begin errors++; $display("FAIL rand_data_L%0d: got %h expected %h", k + 1, m_data[k], e); end
      end
      stall = m_valid[k] && !m_ready[k];
      held = m_data[k];
    end
    hold[k] = 1'b0;
    m_ready[k] = 1'b1;
    checks++;
    if (exp_q[k].size() != 0) begin errors++; $display("FAIL rand_drain_L%0d: %0d words left, expected 0", k + 1, exp_q[k].size()); end
    checks++;
    if (lvl_bad != 0) begin errors++; $display("FAIL rand_level_L%0d: %0d over-depth cycles, expected 0", k + 1, lvl_bad); end
    checks++;
    if (bad_cnt[k] != 0) begin errors++; $display("FAIL rand_empty_issue_L%0d: %0d rinc while empty, expected 0", k + 1, bad_cnt[k]); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    repeat (3) @(negedge rclk);
    m_ready[1] = 1'b0;
    for (int i = 0; i < 8; i++) push(1, 8'hC0 + 8'(i));
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge rclk);
      found = obuf_level[1] == 3'd2;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_setup: level never reached 2, got %0d", obuf_level[1]); end
    checks++;
    if (rinc[1] !== 1'b0) begin errors++; $display("FAIL mid_saturate: rinc=%b expected 0", rinc[1]); end
    rrst = 1'b1;
    hold[1] = 1'b1;
    @(negedge rclk);
    rrst = 1'b0;
    checks++;
    if (m_valid[1] !== 1'b0 || obuf_level[1] !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: m_valid=%b level=%0d expected 0 0", m_valid[1], obuf_level[1]);
    end
    m_ready[1] = 1'b1;
    repeat (4) begin
      @(negedge rclk);
      checks++;
      if (m_valid[1] !== 1'b0 || obuf_level[1] !== 3'd0) begin
        errors++;
        $display("FAIL mid_stale: m_valid=%b level=%0d expected 0 0", m_valid[1], obuf_level[1]);
      end
    end
    src_q[1].delete();
    exp_q[1].delete();
    hold[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure(0);
    test_backpressure(1);
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
